// File: rtl/aes_128_inv_core.sv
// AES-128 inverse cipher, one round per clock. The key schedule is expanded forward into an
// 11-entry round-key file; an optional key cache skips re-expansion when the key repeats.
module aes_128_inv_core #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         IN_valid,
  output logic         IN_ready,
  input  logic [127:0] IN_state,
  input  logic [127:0] key,
  output logic         OUT_valid,
  output logic [127:0] OUT_state
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ADDKEY, ROUND} fsm_t;

  fsm_t         fsm;
  logic [3:0]   rcnt;
  logic [127:0] state_reg;
  logic [127:0] rk [0:10];
  logic         cache_vld;
  logic [127:0] cached_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] bb;
    p  = 8'h00;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ x;
      x  = xtime(x);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] rk_round;
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [127:0] ark;
  logic [127:0] imc;
  logic         cache_hit;

  assign rk_round  = (rcnt <= 4'd10) ? rk[rcnt] : '0;
  assign rk_prev   = (rcnt >= 4'd1 && rcnt <= 4'd11) ? rk[rcnt - 4'd1] : '0;
  assign rk_next   = expand_key(rk_prev, rcon_of(rcnt));
  assign cache_hit = (KEY_CACHE != 0) && cache_vld && (key == cached_key);

  // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r columns.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int SRC = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
    assign ark[127-8*i -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]) ^ rk_round[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      IN_ready  <= 1'b1;
      OUT_valid <= 1'b0;
      OUT_state <= '0;
      rcnt      <= 4'd0;
      cache_vld <= 1'b0;
    end else begin
      OUT_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (IN_valid && IN_ready) begin
            state_reg <= IN_state;
            rk[0]     <= key;
            IN_ready  <= 1'b0;
            if (cache_hit) begin
              fsm  <= ADDKEY;
            end else begin
              fsm  <= KEYEXP;
              rcnt <= 4'd1;
            end
          end
        end
        KEYEXP: begin
          if (rcnt > 4'd10 || rcnt == 4'd0) begin
            fsm      <= IDLE;
            IN_ready <= 1'b1;
            rcnt     <= 4'd0;
          end else begin
            rk[rcnt] <= rk_next;
            if (rcnt == 4'd10) begin
              cache_vld  <= 1'b1;
              cached_key <= rk[0];
              fsm        <= ADDKEY;
            end else begin
              rcnt <= rcnt + 4'd1;
            end
          end
        end
        ADDKEY: begin
          state_reg <= state_reg ^ rk[10];
          rcnt      <= 4'd9;
          fsm       <= ROUND;
        end
        ROUND: begin
          if (rcnt > 4'd9) begin
            fsm      <= IDLE;
            IN_ready <= 1'b1;
            rcnt     <= 4'd0;
          end else if (rcnt == 4'd0) begin
            OUT_state <= ark;
            OUT_valid <= 1'b1;
            IN_ready  <= 1'b1;
            fsm       <= IDLE;
          end else begin
            state_reg <= imc;
            rcnt      <= rcnt - 4'd1;
          end
        end
        default: begin
          fsm      <= IDLE;
          IN_ready <= 1'b1;
          rcnt     <= 4'd0;
        end
      endcase
    end
  end

endmodule
